// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants and
// baud-rate divider values for a 50 MHz system clock at 9600 baud.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    localparam int SYS_CLK_HZ = 50_000_000;
    localparam int BAUD_RATE  = 9600;
    // Rounded divide: clocks per 16x oversample tick (evaluates to 326).
    localparam int BAUD_DIV   = (SYS_CLK_HZ + (BAUD_RATE * OVERSAMPLE) / 2)
                                / (BAUD_RATE * OVERSAMPLE);
    localparam int BAUD_CNT_W = 9;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: holding register, status flags
// and the read-acknowledge strobe.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] parallel_rx_out;
    logic                 rx_valid;
    logic                 rd_ack;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 rx_busy;

    modport master (
        output parallel_rx_out, rx_valid, frame_err, overrun_err, rx_busy,
        input  rd_ack
    );

    modport slave (
        input  parallel_rx_out, rx_valid, frame_err, overrun_err, rx_busy,
        output rd_ack
    );
endinterface

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter; max_tick is high for the one clock where
// the count sits at M-1 just before wrapping.
module mod_m_counter #(
    parameter int N = 9,
    parameter int M = 326
) (
    input  logic clk,
    input  logic rst_n,
    output logic max_tick
);
    logic [N-1:0] r_q;
    logic         w_wrap;

    assign w_wrap   = (r_q == N'(M - 1));
    assign max_tick = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_q <= '0;
        else if (w_wrap) r_q <= '0;
        else             r_q <= r_q + N'(1);
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a
// valid/ack holding register with sticky frame and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = BAUD_DIV,
    parameter int CNT_W     = BAUD_CNT_W,
    parameter int DATA_BITS = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     serial_rx,
    uart_rx_if.master rx_if
);
    localparam int NW = $clog2(DATA_BITS);

    logic                 r_sync1, r_rx_s, r_rx_s_d;
    logic                 w_tick;
    uart_state_t          r_state, w_state_nxt;
    logic [3:0]           r_s_cnt, w_s_cnt_nxt;
    logic [NW-1:0]        r_n_cnt, w_n_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 w_load, w_ferr_set;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_ferr, r_ovr;

    // Line idles high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync1  <= serial_rx;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
        end
    end

    mod_m_counter #(.N(CNT_W), .M(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst),
        .max_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s_cnt <= w_s_cnt_nxt;
            r_n_cnt <= w_n_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_cnt_nxt = r_s_cnt;
        w_n_cnt_nxt = r_n_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                // Edge-triggered arming: a line stuck low never restarts.
                if (r_rx_s_d && !r_rx_s) begin
                    w_state_nxt = START;
                    w_s_cnt_nxt = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'(MID_TICK)) begin
                        if (!r_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_cnt_nxt = '0;
                            w_n_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'(OVERSAMPLE - 1)) begin
                        w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_s_cnt_nxt = '0;
                        if (r_n_cnt == NW'(DATA_BITS - 1)) w_state_nxt = STOP;
                        else                               w_n_cnt_nxt = r_n_cnt + NW'(1);
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == 4'(OVERSAMPLE - 1)) begin
                        w_state_nxt = IDLE;
                        w_s_cnt_nxt = '0;
                        if (r_rx_s) w_load     = 1'b1;
                        else        w_ferr_set = 1'b1;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    // A load coinciding with rd_ack counts as consumed-then-refilled: no overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_ferr  <= 1'b0;
            r_ovr   <= r_valid & ~rx_if.rd_ack;
        end else begin
            if (rx_if.rd_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_ferr_set) r_ferr <= 1'b1;
        end
    end

    assign rx_if.parallel_rx_out = r_data;
    assign rx_if.rx_valid        = r_valid;
    assign rx_if.frame_err       = r_ferr;
    assign rx_if.overrun_err     = r_ovr;
    assign rx_if.rx_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (one bit = 64 clocks); inputs
// change on the falling edge, outputs are sampled on the falling edge.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = CLK_DIV * 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_rx = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    int   last_start = 0;

    uart_rx_if #(.DATA_BITS(8)) rx_if ();

    uart_rx #(.CLK_DIV(CLK_DIV), .CNT_W(3), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_rx (serial_rx),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is on a falling edge; returns on a falling edge with the stop level still driven.
    task automatic send(input logic [7:0] b, input logic stop);
        serial_rx = 1'b0;
        last_start = cyc;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        serial_rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (rx_if.rx_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    task automatic ack();
        rx_if.rd_ack = 1'b1;
        @(negedge clk);
        rx_if.rd_ack = 1'b0;
    endtask

    initial begin
        int lat;
        rx_if.rd_ack = 1'b0;

        #23;
        chk("rst_data",  32'(rx_if.parallel_rx_out), 32'h00);
        chk("rst_valid", 32'(rx_if.rx_valid),        32'd0);
        chk("rst_ferr",  32'(rx_if.frame_err),       32'd0);
        chk("rst_ovr",   32'(rx_if.overrun_err),     32'd0);
        chk("rst_busy",  32'(rx_if.rx_busy),         32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Good frame and its latency from the start edge
        lat = 0;
        fork
            send(8'hA5, 1'b1);
            begin
                wait_valid("a5_wait", 700);
                lat = cyc - last_start;
            end
        join
        chk("a5_latency_ok", 32'(lat >= 600 && lat <= 620), 32'd1);
        chk("a5_data",  32'(rx_if.parallel_rx_out), 32'hA5);
        chk("a5_valid", 32'(rx_if.rx_valid),        32'd1);
        chk("a5_ferr",  32'(rx_if.frame_err),       32'd0);
        chk("a5_busy",  32'(rx_if.rx_busy),         32'd0);
        ack();
        chk("a5_ack_valid", 32'(rx_if.rx_valid), 32'd0);

        // Short low glitch must be rejected at the mid-start sample
        serial_rx = 1'b0;
        repeat (12) @(negedge clk);
        serial_rx = 1'b1;
        chk("glitch_busy_hi", 32'(rx_if.rx_busy), 32'd1);
        repeat (40) @(negedge clk);
        chk("glitch_busy_lo", 32'(rx_if.rx_busy),     32'd0);
        chk("glitch_valid",   32'(rx_if.rx_valid),    32'd0);
        chk("glitch_ferr",    32'(rx_if.frame_err),   32'd0);
        chk("glitch_ovr",     32'(rx_if.overrun_err), 32'd0);

        // Bad stop bit, line held low (no re-arm), then a good frame
        send(8'h3C, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("ferr_set",   32'(rx_if.frame_err), 32'd1);
        chk("ferr_valid", 32'(rx_if.rx_valid),  32'd0);
        chk("ferr_data",  32'(rx_if.parallel_rx_out), 32'hA5);
        chk("ferr_break_idle", 32'(rx_if.rx_busy), 32'd0);
        serial_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send(8'h55, 1'b1);
        chk("55_data",  32'(rx_if.parallel_rx_out), 32'h55);
        chk("55_valid", 32'(rx_if.rx_valid),        32'd1);
        chk("55_ferr",  32'(rx_if.frame_err),       32'd0);
        ack();

        // Back-to-back frames without ack -> overrun
        send(8'h11, 1'b1);
        chk("ovr_11_data", 32'(rx_if.parallel_rx_out), 32'h11);
        chk("ovr_11_ovr",  32'(rx_if.overrun_err),     32'd0);
        send(8'h22, 1'b1);
        chk("ovr_22_data",  32'(rx_if.parallel_rx_out), 32'h22);
        chk("ovr_22_valid", 32'(rx_if.rx_valid),        32'd1);
        chk("ovr_22_ovr",   32'(rx_if.overrun_err),     32'd1);
        ack();
        chk("ovr_ack_valid", 32'(rx_if.rx_valid),    32'd0);
        chk("ovr_ack_ovr",   32'(rx_if.overrun_err), 32'd0);

        // rd_ack on the exact clock the second byte loads; frames are
        // 640 clocks apart (a multiple of the tick period) so the load
        // cycle of frame 2 is frame 1's load cycle plus 640.
        fork
            begin
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
            end
            begin
                int d, tgt, n;
                wait_valid("sim_11_wait", 700);
                d   = cyc - last_start;
                tgt = last_start + 10 * BIT_CLKS + d - 1;
                n   = 0;
                while (cyc < tgt && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk("sim_target_reached", 32'(cyc == tgt), 32'd1);
                ack();
            end
        join
        chk("sim_valid", 32'(rx_if.rx_valid),        32'd1);
        chk("sim_ovr",   32'(rx_if.overrun_err),     32'd0);
        chk("sim_data",  32'(rx_if.parallel_rx_out), 32'h22);

        // Reset in the middle of data bit 3 of 0xFF
        serial_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        serial_rx = 1'b1;
        repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        chk("mid_busy", 32'(rx_if.rx_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mrst_data",  32'(rx_if.parallel_rx_out), 32'h00);
        chk("mrst_valid", 32'(rx_if.rx_valid),        32'd0);
        chk("mrst_ferr",  32'(rx_if.frame_err),       32'd0);
        chk("mrst_ovr",   32'(rx_if.overrun_err),     32'd0);
        chk("mrst_busy",  32'(rx_if.rx_busy),         32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", 32'(rx_if.rx_busy), 32'd0);
        send(8'h81, 1'b1);
        chk("81_data",  32'(rx_if.parallel_rx_out), 32'h81);
        chk("81_valid", 32'(rx_if.rx_valid),        32'd1);
        chk("81_ferr",  32'(rx_if.frame_err),       32'd0);
        chk("81_ovr",   32'(rx_if.overrun_err),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
